// File: rtl/bypass_network.sv
// bypass_network: operand-forwarding unit placed between the ID/EX latch and
// the ALU inputs. Tracks DEPTH in-flight writebacks (stage 0 = youngest) and,
// for each of NREAD read ports, forwards the youngest matching entry. If that
// entry has no data yet, the port falls back to the register file and stall
// is raised.
// Optional feature macro: BYPASS_STATS_EN adds saturating fwd_hits and
// stall_cycles counters.
module bypass_network #(
  parameter int WIDTH   = 32,
  parameter int NREAD   = 2,
  parameter int DEPTH   = 2,
  parameter int REGBITS = 5,
  localparam int SELW   = $clog2(DEPTH + 1)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       advance,
  input  logic                       flush,
  input  logic                       issue_valid,
  input  logic [REGBITS-1:0]         issue_wsel,
  input  logic [DEPTH-1:0]           fill_valid,
  input  logic [DEPTH*WIDTH-1:0]     fill_data,
  input  logic [NREAD*REGBITS-1:0]   rsel,
  input  logic [NREAD*WIDTH-1:0]     rdat_rf,
  output logic [NREAD*WIDTH-1:0]     operand,
  output logic [NREAD*SELW-1:0]      fwd_sel,
  output logic                       stall
`ifdef BYPASS_STATS_EN
  ,
  output logic [15:0]                fwd_hits,
  output logic [15:0]                stall_cycles
`endif
);

  // Registered in-flight entry state
  logic               ent_vld_p0  [DEPTH];
  logic [REGBITS-1:0] ent_wsel_p0 [DEPTH];
  logic               ent_rdy_p0  [DEPTH];
  logic [WIDTH-1:0]   ent_dat_p0  [DEPTH];

  // Entry contents with this cycle's fill applied
  logic               fil_rdy [DEPTH];
  logic [WIDTH-1:0]   fil_dat [DEPTH];

  // Per-port winner: select code, and whether the winner holds data
  logic [SELW-1:0]    win_sel [NREAD];
  logic               win_rdy [NREAD];
  logic [WIDTH-1:0]   win_dat [NREAD];

  // Merge the per-stage fill into each entry
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      fil_rdy[k] = ent_rdy_p0[k] | fill_valid[k];
      fil_dat[k] = fill_valid[k] ? fill_data[k*WIDTH +: WIDTH] : ent_dat_p0[k];
    end
  end

  // Entry shift register: reset > flush > advance > in-place fill
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_vld_p0[k]  <= 1'b0;
        ent_wsel_p0[k] <= '0;
        ent_rdy_p0[k]  <= 1'b0;
        ent_dat_p0[k]  <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_vld_p0[k] <= 1'b0;
      end
    end else if (advance) begin
      ent_vld_p0[0]  <= issue_valid;
      ent_wsel_p0[0] <= issue_wsel;
      ent_rdy_p0[0]  <= 1'b0;
      ent_dat_p0[0]  <= '0;
      for (int k = 1; k < DEPTH; k++) begin
        ent_vld_p0[k]  <= ent_vld_p0[k-1];
        ent_wsel_p0[k] <= ent_wsel_p0[k-1];
        ent_rdy_p0[k]  <= fil_rdy[k-1];
        ent_dat_p0[k]  <= fil_dat[k-1];
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_rdy_p0[k] <= fil_rdy[k];
        ent_dat_p0[k] <= fil_dat[k];
      end
    end
  end

  // Youngest-match search per port; scanning oldest-first lets the youngest overwrite
  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      win_sel[p] = '0;
      win_rdy[p] = 1'b0;
      win_dat[p] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_vld_p0[k] && (ent_wsel_p0[k] == rsel[p*REGBITS +: REGBITS]) &&
            (rsel[p*REGBITS +: REGBITS] != '0)) begin
          win_sel[p] = SELW'(k + 1);
          win_rdy[p] = ent_rdy_p0[k];
          win_dat[p] = ent_dat_p0[k];
        end
      end
    end
  end

  // Operand mux and stall; a not-ready youngest match blocks any older ready one
  always_comb begin
    operand = '0;
    fwd_sel = '0;
    stall   = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      fwd_sel[p*SELW +: SELW] = win_sel[p];
      if ((win_sel[p] != '0) && win_rdy[p]) begin
        operand[p*WIDTH +: WIDTH] = win_dat[p];
      end else begin
        operand[p*WIDTH +: WIDTH] = rdat_rf[p*WIDTH +: WIDTH];
        if (win_sel[p] != '0) begin
          stall = 1'b1;
        end
      end
    end
  end

`ifdef BYPASS_STATS_EN
  logic [15:0] hits_now;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Count ports served from a ready entry this cycle
  always_comb begin
    hits_now = '0;
    for (int p = 0; p < NREAD; p++) begin
      if ((win_sel[p] != '0) && win_rdy[p]) begin
        hits_now = hits_now + 16'd1;
      end
    end
  end

  // Saturating statistics counters; only RST clears them
  always_ff @(posedge CLK) begin
    if (RST) begin
      fwd_hits     <= '0;
      stall_cycles <= '0;
    end else begin
      fwd_hits     <= sat_add16(fwd_hits, hits_now);
      stall_cycles <= sat_add16(stall_cycles, {15'd0, stall});
    end
  end
`endif

endmodule
